// File: rtl/i2d_core_defines.sv
// Shared i2d core types: data word, ALU flags, register address and WB FSM states.
package i2d_core_defines;

    localparam int I2D_REG_AW = 5;
    localparam int I2D_DATA_W = 32;

    typedef logic [I2D_DATA_W-1:0] data_t;
    typedef logic [I2D_REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic cf;
        logic of;
        logic zf;
    } flag_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/core_wb_flagreg.sv
// Architectural flag register; its output feeds back to the ALU flag input.
module core_wb_flagreg
    import i2d_core_defines::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  flag_t d,
    output flag_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/core_wb.sv
// i2d writeback stage: commits ALU/load results, owns flags, tracks one outstanding load.
// Optional early forwarding port enabled by defining CORE_WB_FWD_EN.
module core_wb
    import i2d_core_defines::*;
#(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_halt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wen,
    input  logic              ex_flag_wen,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] alu_result,
    input  flag_t             alu_flag,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output flag_t             flag_out,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              wb_busy,
    output logic              wb_err
);

    wb_state_t         state;
    wb_state_t         state_nxt;
    logic              accept;
    logic              alu_commit;
    logic              ld_commit;
    logic              flag_we;
    logic [REG_AW-1:0] ld_rd_p0;
    logic              ld_wen_p0;

    assign ex_ready   = (state == WB_IDLE) & ~ex_halt & ~rst;
    assign accept     = ex_valid & ex_ready;
    assign alu_commit = accept & ~ex_is_load & ex_wen & (ex_rd != REG_AW'(REG_ZERO));
    assign ld_commit  = (state == WB_WAIT_LOAD) & ld_valid & ld_wen_p0
                        & (ld_rd_p0 != REG_AW'(REG_ZERO));
    assign flag_we    = accept & ~ex_is_load & ex_flag_wen;
    assign wb_busy    = (state == WB_WAIT_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE: begin
                if (accept && ex_is_load) begin
                    state_nxt = WB_WAIT_LOAD;
                end
            end
            WB_WAIT_LOAD: begin
                if (ld_valid) begin
                    state_nxt = WB_IDLE;
                end
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    // Stage p0: destination of the outstanding load, held until its data returns
    always_ff @(posedge clk) begin
        if (accept && ex_is_load) begin
            ld_rd_p0  <= ex_rd;
            ld_wen_p0 <= ex_wen;
        end
    end

    // Stage p1: register-file write port; address/data only move on a real commit
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_err   <= 1'b0;
        end else begin
            rf_we  <= alu_commit | ld_commit;
            wb_err <= (state == WB_IDLE) & ld_valid;
            if (alu_commit) begin
                rf_waddr <= ex_rd;
                rf_wdata <= alu_result;
            end else if (ld_commit) begin
                rf_waddr <= ld_rd_p0;
                rf_wdata <= ld_data;
            end
        end
    end

    core_wb_flagreg u_flagreg (
        .clk (clk),
        .rst (rst),
        .we  (flag_we),
        .d   (alu_flag),
        .q   (flag_out)
    );

`ifdef CORE_WB_FWD_EN
    // Returning load data is bypassed a cycle early, ahead of its own rf commit
    always_comb begin
        fwd_valid = rf_we;
        fwd_rd    = rf_waddr;
        fwd_data  = rf_wdata;
        if (ld_commit && !rst) begin
            fwd_valid = 1'b1;
            fwd_rd    = ld_rd_p0;
            fwd_data  = ld_data;
        end
    end
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_core_wb.sv
// Randomized self-checking bench for core_wb against a transaction-level model.
module tb_core_wb;
    import i2d_core_defines::*;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_halt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wen;
    logic              ex_flag_wen;
    logic              ex_is_load;
    logic [DATA_W-1:0] alu_result;
    flag_t             alu_flag;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    flag_t             flag_out;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic              wb_busy;
    logic              wb_err;

    int checks = 0;
    int errors = 0;

    // Model: one outstanding load at most, plus the last visible commit
    bit                m_busy = 0;
    logic [REG_AW-1:0] m_rd   = '0;
    bit                m_wen  = 0;
    bit                e_we   = 0;
    logic [REG_AW-1:0] e_waddr = '0;
    logic [DATA_W-1:0] e_wdata = '0;
    logic [2:0]        e_flag = '0;
    bit                e_err  = 0;

    always #5 clk = ~clk;

    core_wb #(.REG_AW(REG_AW), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_halt     (ex_halt),
        .ex_rd       (ex_rd),
        .ex_wen      (ex_wen),
        .ex_flag_wen (ex_flag_wen),
        .ex_is_load  (ex_is_load),
        .alu_result  (alu_result),
        .alu_flag    (alu_flag),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .flag_out    (flag_out),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .wb_busy     (wb_busy),
        .wb_err      (wb_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_fwd(input string tag);
        bit                fv = 0;
        logic [REG_AW-1:0] fr = '0;
        logic [DATA_W-1:0] fd = '0;
`ifdef CORE_WB_FWD_EN
        fv = e_we;
        fr = e_waddr;
        fd = e_wdata;
        if (!rst && m_busy && ld_valid && m_wen && m_rd != 0) begin
            fv = 1;
            fr = m_rd;
            fd = ld_data;
        end
`endif
        chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'(fv));
        chk({tag, "_fwd_rd"}, 64'(fwd_rd), 64'(fr));
        chk({tag, "_fwd_data"}, 64'(fwd_data), 64'(fd));
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_halt = 0; ex_rd = '0; ex_wen = 0; ex_flag_wen = 0;
        ex_is_load = 0; alu_result = '0; alu_flag = '0; ld_valid = 0; ld_data = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs
    task automatic tick();
        bit rdy;
        #1;
        rdy = !m_busy && !ex_halt && !rst;
        chk("ex_ready", 64'(ex_ready), 64'(rdy));
        if (!rst) chk_fwd("pre");
        if (rst) begin
            m_busy = 0; e_we = 0; e_waddr = '0; e_wdata = '0; e_flag = '0; e_err = 0;
        end else begin
            e_we  = 0;
            e_err = 0;
            if (!m_busy) begin
                if (ld_valid) e_err = 1;
                if (ex_valid && rdy) begin
                    if (ex_is_load) begin
                        m_busy = 1; m_rd = ex_rd; m_wen = ex_wen;
                    end else begin
                        if (ex_wen && ex_rd != 0) begin
                            e_we = 1; e_waddr = ex_rd; e_wdata = alu_result;
                        end
                        if (ex_flag_wen) e_flag = alu_flag;
                    end
                end
            end else if (ld_valid) begin
                m_busy = 0;
                if (m_wen && m_rd != 0) begin
                    e_we = 1; e_waddr = m_rd; e_wdata = ld_data;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("rf_we", 64'(rf_we), 64'(e_we));
        chk("rf_waddr", 64'(rf_waddr), 64'(e_waddr));
        chk("rf_wdata", 64'(rf_wdata), 64'(e_wdata));
        chk("flag_out", 64'(flag_out), 64'(e_flag));
        chk("wb_busy", 64'(wb_busy), 64'(m_busy));
        chk("wb_err", 64'(wb_err), 64'(e_err));
        chk_fwd("post");
    endtask

    initial begin
        int busy_cnt;
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;

        // Reset
        tick();
        tick();
        chk("reset_rf_we", 64'(rf_we), 64'h0);
        chk("reset_flag", 64'(flag_out), 64'h0);
        rst = 0;

        // ALU commit with flags
        ex_valid = 1; ex_rd = 5'd3; ex_wen = 1; ex_flag_wen = 1;
        alu_result = 32'h0000_0005; alu_flag = 3'b100;
        tick();
        chk("alu_wdata", 64'(rf_wdata), 64'h5);
        chk("alu_flag", 64'(flag_out), 64'h4);

        // r0 write suppression
        ex_rd = 5'd0; ex_flag_wen = 0; alu_result = 32'hFFFF_FFFF;
        tick();
        chk("r0_we", 64'(rf_we), 64'h0);
        chk("r0_fwd", 64'(fwd_valid), 64'h0);

        // Load to r7, data back after 3 idle cycles; flag_wen must be ignored
        ex_is_load = 1; ex_rd = 5'd7; ex_flag_wen = 1; alu_flag = 3'b011;
        tick();
        busy_cnt = int'(wb_busy);
        idle_inputs();
        ex_valid = 1; ex_rd = 5'd12; ex_wen = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            busy_cnt += int'(wb_busy);
        end
        chk("ld_busy_cycles", 64'(busy_cnt), 64'd4);
        idle_inputs();
        ld_valid = 1; ld_data = 32'hDEAD_BEEF;
        tick();
        chk("ld_waddr", 64'(rf_waddr), 64'd7);
        chk("ld_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        chk("ld_flag", 64'(flag_out), 64'h4);

        // Halt while a load is outstanding
        idle_inputs();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd9; ex_wen = 1;
        tick();
        idle_inputs();
        ex_halt = 1; ex_valid = 1;
        tick();
        ld_valid = 1; ld_data = 32'h1234_5678;
        tick();
        chk("halt_ld_we", 64'(rf_we), 64'h1);
        ld_valid = 0;
        tick();
        chk("halt_ready", 64'(ex_ready), 64'h0);
        ex_halt = 0; ex_valid = 0;
        tick();

        // Reset while waiting for a load, then a stray ld_valid
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; ex_wen = 1;
        tick();
        idle_inputs();
        rst = 1;
        tick();
        chk("rst_busy", 64'(wb_busy), 64'h0);
        rst = 0;
        ld_valid = 1; ld_data = 32'hCAFE_F00D;
        tick();
        chk("stray_err", 64'(wb_err), 64'h1);
        chk("stray_we", 64'(rf_we), 64'h0);
        ld_valid = 0;
        tick();
        chk("stray_err_once", 64'(wb_err), 64'h0);

        // Back-to-back ALU commits
        for (int i = 1; i <= 4; i++) begin
            ex_valid = 1; ex_wen = 1; ex_rd = REG_AW'(i); alu_result = $urandom;
            tick();
            chk("b2b_we", 64'(rf_we), 64'h1);
            chk("b2b_waddr", 64'(rf_waddr), 64'(i));
        end
        idle_inputs();
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            ex_valid    = ($urandom_range(0, 9) < 7);
            ex_halt     = ($urandom_range(0, 99) < 15);
            ex_is_load  = ($urandom_range(0, 3) == 0);
            ex_wen      = ($urandom_range(0, 99) < 85);
            ex_flag_wen = ($urandom_range(0, 1) == 1);
            ex_rd       = ($urandom_range(0, 9) == 0) ? '0 : REG_AW'($urandom_range(0, 31));
            alu_result  = $urandom;
            alu_flag    = 3'($urandom_range(0, 7));
            ld_valid    = m_busy ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 3);
            ld_data     = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_wb.md
Name: core_wb

Overview:
- Writeback stage of the i2d core.
- Consumes EX-stage results (ALU result, ALU flags, load requests) and commits them to the register-file write port.
- Owns the architectural flag register, which feeds the ALU flag input.
- Tracks outstanding loads and drives forwarding data back to the EX operand muxes.

Parameters:
- REG_AW, 5, register address width (32 GPRs; r0 hardwired zero)
- DATA_W, 32, data width (matches data_t)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX presents an instruction result
- ex_ready  out  1  WB accepts this cycle
- ex_halt  in  1  pipeline halt; blocks acceptance
- ex_rd  in  REG_AW  destination register
- ex_wen  in  1  instruction writes rd
- ex_flag_wen  in  1  instruction updates flags
- ex_is_load  in  1  result comes from memory, not the ALU
- alu_result  in  DATA_W  ALU result
- alu_flag  in  flag_t  ALU flags {cf, of, zf}
- ld_valid  in  1  load data return strobe
- ld_data  in  DATA_W  load return data
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  DATA_W  write data
- flag_out  out  flag_t  architectural flags; feeds ALU flag_in
- fwd_valid  out  1  forwarding entry valid
- fwd_rd  out  REG_AW  forwarding register
- fwd_data  out  DATA_W  forwarding value
- wb_busy  out  1  load outstanding
- wb_err  out  1  one-cycle pulse on unexpected ld_valid

Behaviour:
- Clock and reset:
  - One clock: clk. Reset rst is synchronous and active-high.
  - Reset values: state=IDLE; rf_we=0; rf_waddr=0; rf_wdata=0; flag_out=0; fwd_valid=0; fwd_rd=0; fwd_data=0; wb_busy=0; wb_err=0.
- ex_ready:
  - ex_ready = (state==IDLE) & !ex_halt & !rst. Combinational.
  - Accept = ex_valid & ex_ready.
- FSM states: IDLE, WAIT_LOAD.
- IDLE, accept with ex_is_load=0:
  - In cycle N+1: rf_we = ex_wen & (ex_rd!=0); rf_waddr = ex_rd; rf_wdata = alu_result (registered at N).
  - If ex_flag_wen, flag_out <= alu_flag at the N+1 edge, so it is visible in N+1.
  - Latency is 1 cycle.
- IDLE, accept with ex_is_load=1:
  - Latch rd and wen; go to WAIT_LOAD; wb_busy=1.
  - Flags never change on loads (ex_flag_wen ignored).
- WAIT_LOAD:
  - On ld_valid: capture ld_data; in the next cycle rf_we = latched wen & (rd!=0), rf_wdata = ld_data. Return to IDLE at the same edge.
  - wb_busy=0 from the cycle after ld_valid.
- ld_valid in IDLE: data is dropped, no write, and wb_err pulses 1 in the next cycle.
- ex_halt:
  - Blocks new acceptance only.
  - A write already registered still commits.
  - WAIT_LOAD still completes on ld_valid.
- Writes to r0 are suppressed: rf_we=0. Forwarding is also suppressed for r0.
- rf_we is a single-cycle pulse per committed instruction. rf_waddr and rf_wdata hold their last values when rf_we=0.
- Reset mid-load returns to IDLE. The outstanding load is abandoned; a later ld_valid raises wb_err.
- Back-to-back ALU results: one commit per cycle, no bubbles.

Optional Feature:
- Macro: CORE_WB_FWD_EN.
- Defined:
  - fwd_valid/fwd_rd/fwd_data mirror rf_we/rf_waddr/rf_wdata in the same cycle.
  - Additionally, in WAIT_LOAD the cycle ld_valid is high, fwd_* presents ld_data for the latched rd combinationally (early bypass).
- Undefined: fwd_valid tied 0; fwd_rd and fwd_data tied 0.

Decomposition:
- Shared package i2d_core_defines.sv gains:
  - wb_state_t enum {WB_IDLE, WB_WAIT_LOAD}
  - reg_addr_t (REG_AW bits)
  - REG_ZERO constant
- Reuse the existing flag_t and data_t from that package.
- One natural sub-module: core_wb_flagreg. It holds the flag register with write-enable and synchronous reset, isolating the feedback to the ALU flag input.

Test Plan:
- ALU commit: accept rd=3, alu_result=0x0000_0005, ex_flag_wen=1, alu_flag={cf=1,of=0,zf=0} -> next cycle rf_we=1, rf_waddr=3, rf_wdata=5, flag_out={1,0,0}.
- r0 suppression: accept rd=0, alu_result=0xFFFF_FFFF, ex_wen=1 -> rf_we stays 0, fwd_valid=0.
- Load: accept ex_is_load=1, rd=7; ld_valid after 3 cycles with 0xDEAD_BEEF -> ex_ready=0 and wb_busy=1 for 4 cycles; rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF one cycle after ld_valid; flag_out unchanged.
- Halt during load: ex_halt=1 while in WAIT_LOAD, ld_valid arrives -> write still commits; ex_ready stays 0 until ex_halt drops.
- Unexpected/reset: assert rst in WAIT_LOAD, then pulse ld_valid -> no rf_we, wb_err=1 for exactly one cycle, all outputs at reset values after rst.
- Back-to-back: 4 consecutive ALU accepts to rd=1..4 -> 4 consecutive rf_we pulses with matching addr/data; with CORE_WB_FWD_EN, fwd_* mirrors each pulse.
